// File: rtl/tinyalu_pkg.sv
// Shared types for the TinyALU requester: opcodes, error codes, FSM states and the queued command.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_MUL = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_ILLEGAL = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] b;
    logic [7:0] a;
  } cmd_t;

  // Encodings above MUL have no ALU operation behind them.
  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full and empty are distinct.
module cmd_fifo
  import tinyalu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/tinyalu_requester.sv
// Queues ALU commands and sequences them through the ALU start/done handshake with a timeout.
//   state    | meaning
//   ST_IDLE  | waiting for a queued command; pops the head when one is present
//   ST_ISSUE | alu_start high, operands held, waiting for alu_done or timeout
//   ST_RESP  | rsp_valid high with stable result/err until rsp_ready
module tinyalu_requester
  import tinyalu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [1:0]  rsp_err,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e        state;
  logic [TW-1:0] tmo_cnt;
  cmd_t          in_cmd;
  cmd_t          head;
  logic          full;
  logic          empty;
  logic          pop;

  assign in_cmd = '{op: cmd_op, b: cmd_b, a: cmd_a};
  assign pop    = (state == ST_IDLE) && !empty;

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data (in_cmd),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign cmd_ready = !full;
  assign busy      = (state != ST_IDLE) || !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      tmo_cnt    <= '0;
      alu_start  <= 1'b0;
      alu_A      <= '0;
      alu_B      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            if (head.op == OP_NOP || !op_is_legal(head.op)) begin
              state      <= ST_RESP;
              rsp_valid  <= 1'b1;
              rsp_result <= '0;
              rsp_err    <= (head.op == OP_NOP) ? ERR_OK : ERR_ILLEGAL;
            end else begin
              state     <= ST_ISSUE;
              alu_A     <= head.a;
              alu_B     <= head.b;
              alu_op    <= head.op;
              alu_start <= 1'b1;
              tmo_cnt   <= '0;
            end
          end
        end
        ST_ISSUE: begin
          // done is checked first so a done on the final allowed cycle still succeeds
          if (alu_done) begin
            state      <= ST_RESP;
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_err    <= ERR_OK;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state      <= ST_RESP;
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_result <= '0;
            rsp_err    <= ERR_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_requester.sv
// Directed bench for tinyalu_requester with a behavioural ALU whose done latency is programmable.
module tb_tinyalu_requester;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [1:0]  rsp_err;
  logic [7:0]  alu_A;
  logic [7:0]  alu_B;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        busy;

  int num_checks = 0;
  int failures   = 0;

  // ALU model state: done fires on the alu_lat-th consecutive start cycle
  bit          alu_en = 1'b1;
  int          alu_lat = 1;
  int          start_run = 0;
  int          last_run = 0;
  int          total_starts = 0;
  int          unstable_cnt = 0;
  logic [18:0] run_ops = '0;

  always #5 clk = ~clk;

  tinyalu_requester #(.FIFO_DEPTH(4), .TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .busy       (busy)
  );

  always_comb begin
    alu_result = 16'h0000;
    case (alu_op)
      3'b001:  alu_result = {8'h00, alu_A} + {8'h00, alu_B};
      3'b010:  alu_result = {8'h00, alu_A & alu_B};
      3'b011:  alu_result = {8'h00, alu_A ^ alu_B};
      3'b100:  alu_result = 16'(alu_A) * 16'(alu_B);
      default: alu_result = 16'h0000;
    endcase
  end

  assign alu_done = alu_en && alu_start && (start_run == alu_lat - 1);

  always @(posedge clk) begin
    if (alu_start) begin
      start_run <= start_run + 1;
      if (start_run == 0) begin
        total_starts <= total_starts + 1;
        run_ops      <= {alu_op, alu_B, alu_A};
      end else if ({alu_op, alu_B, alu_A} !== run_ops) begin
        unstable_cnt <= unstable_cnt + 1;
      end
    end else begin
      if (start_run != 0) last_run <= start_run;
      start_run <= 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", failures);
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bit acc;
    acc = 1'b0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    num_checks++;
    if (!acc) begin
      failures++;
      $display("FAIL cmd_accept: command a=%h b=%h op=%b not accepted, required acceptance within 100 cycles", a, b, op);
    end
  endtask

  task automatic get_rsp(output logic [15:0] res, output logic [1:0] err, output bit got);
    got = 1'b0;
    res = 'x;
    err = 'x;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        res = rsp_result;
        err = rsp_err;
        got = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b1;
    #1;
    num_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: cmd_ready=%b rsp_valid=%b busy=%b, required 1 0 0", cmd_ready, rsp_valid, busy);
    end
    num_checks++;
    if ({rsp_result, rsp_err} !== 18'h0) begin
      failures++;
      $display("FAIL reset_rsp: result=%h err=%b, required 0000 00", rsp_result, rsp_err);
    end
    num_checks++;
    if ({alu_start, alu_A, alu_B, alu_op} !== 20'h0) begin
      failures++;
      $display("FAIL reset_alu: start=%b A=%h B=%h op=%b, required all zero", alu_start, alu_A, alu_B, alu_op);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_add();
    logic [15:0] res; logic [1:0] err; bit got;
    alu_en = 1'b1; alu_lat = 1;
    send_cmd(8'hFF, 8'h01, 3'b001);
    @(negedge clk);
    num_checks++;
    if (alu_start !== 1'b0) begin
      failures++; $display("FAIL add_cycle1_start: alu_start=%b, required 0", alu_start);
    end
    @(negedge clk);
    num_checks++;
    if (alu_start !== 1'b1) begin
      failures++; $display("FAIL add_cycle2_start: alu_start=%b, required 1", alu_start);
    end
    num_checks++;
    if ({alu_A, alu_B, alu_op} !== {8'hFF, 8'h01, 3'b001}) begin
      failures++; $display("FAIL add_operands: A=%h B=%h op=%b, required FF 01 001", alu_A, alu_B, alu_op);
    end
    get_rsp(res, err, got);
    num_checks++;
    if (!got || res !== 16'h0100 || err !== 2'b00) begin
      failures++; $display("FAIL add_rsp: got=%0d result=%h err=%b, required 1 0100 00", got, res, err);
    end
    num_checks++;
    if (last_run !== 1) begin
      failures++; $display("FAIL add_start_len: alu_start held %0d cycles, required 1", last_run);
    end
  endtask

  task automatic test_mul();
    logic [15:0] res; logic [1:0] err; bit got; int unst0;
    alu_en = 1'b1; alu_lat = 3; unst0 = unstable_cnt;
    send_cmd(8'hFF, 8'hFF, 3'b100);
    get_rsp(res, err, got);
    num_checks++;
    if (!got || res !== 16'hFE01 || err !== 2'b00) begin
      failures++; $display("FAIL mul_rsp: got=%0d result=%h err=%b, required 1 FE01 00", got, res, err);
    end
    num_checks++;
    if (last_run !== 3) begin
      failures++; $display("FAIL mul_start_len: alu_start held %0d cycles, required 3", last_run);
    end
    num_checks++;
    if (unstable_cnt !== unst0) begin
      failures++; $display("FAIL mul_operands_stable: %0d unstable cycles, required 0", unstable_cnt - unst0);
    end
  endtask

  task automatic test_illegal_nop();
    logic [15:0] res; logic [1:0] err; bit got; int s0;
    s0 = total_starts;
    rsp_ready = 1'b0;
    send_cmd(8'h12, 8'h34, 3'b110);
    send_cmd(8'h56, 8'h78, 3'b000);
    rsp_ready = 1'b1;
    get_rsp(res, err, got);
    num_checks++;
    if (!got || res !== 16'h0000 || err !== 2'b01) begin
      failures++; $display("FAIL illegal_rsp: got=%0d result=%h err=%b, required 1 0000 01", got, res, err);
    end
    get_rsp(res, err, got);
    num_checks++;
    if (!got || res !== 16'h0000 || err !== 2'b00) begin
      failures++; $display("FAIL nop_rsp: got=%0d result=%h err=%b, required 1 0000 00", got, res, err);
    end
    num_checks++;
    if (total_starts !== s0) begin
      failures++; $display("FAIL illegal_nop_no_start: %0d alu_start pulses, required 0", total_starts - s0);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] res; logic [1:0] err; bit got;
    alu_en = 1'b0;
    send_cmd(8'h03, 8'h04, 3'b001);
    get_rsp(res, err, got);
    num_checks++;
    if (!got || res !== 16'h0000 || err !== 2'b10) begin
      failures++; $display("FAIL timeout_rsp: got=%0d result=%h err=%b, required 1 0000 10", got, res, err);
    end
    num_checks++;
    if (last_run !== 15) begin
      failures++; $display("FAIL timeout_start_len: alu_start held %0d cycles, required 15", last_run);
    end
    alu_en = 1'b1; alu_lat = 1;
    send_cmd(8'h5A, 8'h0F, 3'b011);
    get_rsp(res, err, got);
    num_checks++;
    if (!got || res !== 16'h0055 || err !== 2'b00) begin
      failures++; $display("FAIL after_timeout_xor: got=%0d result=%h err=%b, required 1 0055 00", got, res, err);
    end
    send_cmd(8'hF0, 8'h3C, 3'b010);
    get_rsp(res, err, got);
    num_checks++;
    if (!got || res !== 16'h0030 || err !== 2'b00) begin
      failures++; $display("FAIL and_rsp: got=%0d result=%h err=%b, required 1 0030 00", got, res, err);
    end
    // done arriving on the last allowed cycle must beat the timeout
    alu_lat = 15;
    send_cmd(8'h10, 8'h25, 3'b001);
    get_rsp(res, err, got);
    num_checks++;
    if (!got || res !== 16'h0035 || err !== 2'b00) begin
      failures++; $display("FAIL done_at_timeout: got=%0d result=%h err=%b, required 1 0035 00", got, res, err);
    end
    num_checks++;
    if (last_run !== 15) begin
      failures++; $display("FAIL done_at_timeout_len: alu_start held %0d cycles, required 15", last_run);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] res; logic [1:0] err; bit got; int accepted;
    alu_en = 1'b1; alu_lat = 1; rsp_ready = 1'b0; accepted = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send_cmd(8'(8'h10 + i), 8'(i), 3'b001);
          accepted++;
        end
      end
      begin
        repeat (30) @(negedge clk);
        num_checks++;
        if (accepted !== 5 || cmd_ready !== 1'b0) begin
          failures++; $display("FAIL bp_stall: accepted=%0d cmd_ready=%b, required 5 0", accepted, cmd_ready);
        end
        num_checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 16'h0010 || busy !== 1'b1) begin
          failures++; $display("FAIL bp_hold: rsp_valid=%b result=%h busy=%b, required 1 0010 1", rsp_valid, rsp_result, busy);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
          get_rsp(res, err, got);
          num_checks++;
          if (!got || res !== 16'(16'h0010 + 2 * i) || err !== 2'b00) begin
            failures++;
            $display("FAIL bp_order[%0d]: got=%0d result=%h err=%b, required 1 %h 00", i, got, res, err, 16'(16'h0010 + 2 * i));
          end
        end
      end
    join
    repeat (3) @(negedge clk);
    num_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL bp_drain: busy=%b rsp_valid=%b, required 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_issue();
    logic [15:0] res; logic [1:0] err; bit got; bit seen;
    alu_en = 1'b0;
    send_cmd(8'h12, 8'h34, 3'b100);
    send_cmd(8'h01, 8'h02, 3'b001);
    @(negedge clk);
    num_checks++;
    if (alu_start !== 1'b1 || alu_op !== 3'b100) begin
      failures++; $display("FAIL rst_pre_issue: alu_start=%b op=%b, required 1 100", alu_start, alu_op);
    end
    #2 reset = 1'b1;
    #1;
    num_checks++;
    if (alu_start !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_async: alu_start=%b busy=%b cmd_ready=%b rsp_valid=%b, required 0 0 1 0", alu_start, busy, cmd_ready, rsp_valid);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    alu_en = 1'b1; alu_lat = 1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid || alu_start) seen = 1'b1;
    end
    num_checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL rst_discard: activity after reset=%b, required 0", seen);
    end
    @(posedge clk);
    #1;
    send_cmd(8'h22, 8'h11, 3'b001);
    get_rsp(res, err, got);
    num_checks++;
    if (!got || res !== 16'h0033 || err !== 2'b00) begin
      failures++; $display("FAIL rst_fresh_add: got=%0d result=%h err=%b, required 1 0033 00", got, res, err);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_illegal_nop();
    test_timeout();
    test_back_to_back();
    test_reset_mid_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, failures);
    $finish;
  end

endmodule
